key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 256 +++++++++++++++++++++++++
 tb/tb_key_debounce.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Input-conditioning front end for the countdown controller. Five raw,
// active-low, asynchronous push-buttons are synchronised to i_clkin and
// debounced independently. Each key gives a debounced level plus registered
// single-cycle press, release and auto-repeat strobes.
//
// Ports
//   i_clkin        system clock
//   i_rst          synchronous active-high reset
//   i_key_n[4:0]   raw buttons, active-low (0 enter, 1 up, 2 down, 3 left, 4 right)
//   o_key_lvl      debounced level, 1 = pressed
//   o_key_press    one-cycle strobe when a press is accepted
//   o_key_rel      one-cycle strobe when a release is accepted
//   o_key_rpt      one-cycle auto-repeat strobe while a key stays held
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// key_debounce_chan
//
// Debounce FSM for one synchronised key.
//
// Ports
//   i_clkin   system clock
//   i_rst     synchronous active-high reset
//   i_s       synchronised raw key, active-low (0 = pressed)
//   o_lvl     debounced level, 1 = pressed
//   o_press   press strobe
//   o_rel     release strobe
//   o_rpt     auto-repeat strobe (constant 0 when RPT_EN = 0)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | released and stable, waiting for the first low sample
// PDB     | press debounce, counting consecutive low samples
// HELD    | accepted press, hold/repeat timer running
// RDB     | release debounce, counting consecutive high samples
// -----------------------------------------------------------------------------
module key_debounce_chan #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int HOLD_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter bit RPT_EN       = 1'b0
) (
    input  logic i_clkin,
    input  logic i_rst,
    input  logic i_s,
    output logic o_lvl,
    output logic o_press,
    output logic o_rel,
    output logic o_rpt
);

    localparam int HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW       = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PDB  = 2'd1,
        ST_HELD = 2'd2,
        ST_RDB  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hold;
    logic          r_rpt_seen;
    logic          r_lvl;
    logic          r_press;
    logic          r_rel;
    logic          r_rpt;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [HW-1:0] w_hold_nxt;
    logic          w_rpt_seen_nxt;
    logic          w_lvl_nxt;
    logic          w_press_nxt;
    logic          w_rel_nxt;
    logic          w_rpt_nxt;
    logic          w_hold_run;
    logic [HW-1:0] w_hold_cmp;

    // The first repeat waits the long hold time, later ones the short period.
    assign w_hold_cmp = r_rpt_seen ? RPT_LAST : HOLD_LAST;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_hold_nxt     = r_hold;
        w_rpt_seen_nxt = r_rpt_seen;
        w_lvl_nxt      = r_lvl;
        w_press_nxt    = 1'b0;
        w_rel_nxt      = 1'b0;
        w_rpt_nxt      = 1'b0;
        w_hold_run     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!i_s) begin
                    w_state_nxt = ST_PDB;
                    w_cnt_nxt   = '0;
                end
            end

            ST_PDB: begin
                if (i_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = ST_HELD;
                    w_cnt_nxt      = '0;
                    w_press_nxt    = 1'b1;
                    w_lvl_nxt      = 1'b1;
                    w_hold_nxt     = '0;
                    w_rpt_seen_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            ST_HELD: begin
                w_hold_run = 1'b1;
                if (i_s) begin
                    w_state_nxt = ST_RDB;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RDB: begin
                if (!i_s) begin
                    // Bounce during release: back to HELD without disturbing
                    // the repeat timing.
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_hold_run  = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = '0;
                    w_rel_nxt      = 1'b1;
                    w_lvl_nxt      = 1'b0;
                    w_hold_nxt     = '0;
                    w_rpt_seen_nxt = 1'b0;
                end else begin
                    w_cnt_nxt  = r_cnt + CW'(1);
                    w_hold_run = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // The release edge leaves w_hold_run low, so a repeat can never
        // coincide with the release strobe. Non-repeating keys just let the
        // hold counter saturate.
        if (w_hold_run) begin
            if (RPT_EN && (r_hold == w_hold_cmp)) begin
                w_rpt_nxt      = 1'b1;
                w_hold_nxt     = '0;
                w_rpt_seen_nxt = 1'b1;
            end else if (r_hold != {HW{1'b1}}) begin
                w_hold_nxt = r_hold + HW'(1);
            end
        end
    end

    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_rpt_seen <= 1'b0;
            r_lvl      <= 1'b0;
            r_press    <= 1'b0;
            r_rel      <= 1'b0;
            r_rpt      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold     <= w_hold_nxt;
            r_rpt_seen <= w_rpt_seen_nxt;
            r_lvl      <= w_lvl_nxt;
            r_press    <= w_press_nxt;
            r_rel      <= w_rel_nxt;
            r_rpt      <= w_rpt_nxt;
        end
    end

    assign o_lvl   = r_lvl;
    assign o_press = r_press;
    assign o_rel   = r_rel;
    assign o_rpt   = r_rpt;

endmodule

// -----------------------------------------------------------------------------
// key_debounce (top): two-flop synchroniser per key feeding five independent
// debounce channels.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int         DEBOUNCE_CYC = 1000000,
    parameter int         HOLD_CYC     = 50000000,
    parameter int         REPEAT_CYC   = 10000000,
    parameter logic [4:0] RPT_MASK     = 5'b00110
) (
    input  logic       i_clkin,
    input  logic       i_rst,
    input  logic [4:0] i_key_n,
    output logic [4:0] o_key_lvl,
    output logic [4:0] o_key_press,
    output logic [4:0] o_key_rel,
    output logic [4:0] o_key_rpt
);

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;

    // Synchroniser resets to "released" so a key held through reset is seen
    // as a fresh press once reset lifts.
    always_ff @(posedge i_clkin) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_key
        key_debounce_chan #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .RPT_EN       (RPT_MASK[g])
        ) u_chan (
            .i_clkin (i_clkin),
            .i_rst   (i_rst),
            .i_s     (r_sync2[g]),
            .o_lvl   (o_key_lvl[g]),
            .o_press (o_key_press[g]),
            .o_rel   (o_key_rel[g]),
            .o_rpt   (o_key_rpt[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Drives directed and random button waveforms into key_debounce. A reference
// model works on runs of samples: a level change is accepted once the
// synchronised key has disagreed with the accepted level for DEBOUNCE_CYC+1
// consecutive edges, and repeats fall at press_edge + HOLD + k*REPEAT.
// Expected strobe events are queued; a monitor pops and compares whenever the
// DUT raises any strobe.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int         D    = 4;
    localparam int         HOLD = 20;
    localparam int         RPT  = 8;
    localparam logic [4:0] MASK = 5'b00110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_n;
    logic [4:0] key_lvl, key_press, key_rel, key_rpt;

    key_debounce #(
        .DEBOUNCE_CYC (D),
        .HOLD_CYC     (HOLD),
        .REPEAT_CYC   (RPT),
        .RPT_MASK     (MASK)
    ) dut (
        .i_clkin     (clk),
        .i_rst       (rst),
        .i_key_n     (key_n),
        .o_key_lvl   (key_lvl),
        .o_key_press (key_press),
        .o_key_rel   (key_rel),
        .o_key_rpt   (key_rpt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         edge_n;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] rpt;
    } ev_t;

    ev_t        exp_q[$];
    logic [4:0] exp_lvl [int];
    bit         rst_edge [int];

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [4:0] m_d1 = '1, m_d2 = '1, m_acc = '0;
    int         m_run [5];
    int         m_tp  [5];

    // monitor observations
    int         obs_press [5], obs_rel [5], obs_rpt [5];
    int         last_press_edge [5], last_rel_edge [5], last_rpt_edge [5];
    logic [4:0] last_press_vec = '0;
    int         base_press [5], base_rel [5], base_rpt [5];

    task automatic check(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 5; i++) begin
            base_press[i] = obs_press[i];
            base_rel[i]   = obs_rel[i];
            base_rpt[i]   = obs_rpt[i];
        end
    endtask

    // Apply one edge's worth of stimulus and advance the model for that edge.
    task automatic step(input logic r, input logic [4:0] kn);
        int         n;
        logic [4:0] s, pr, rl, rp;
        ev_t        e;
        rst   = r;
        key_n = kn;
        n  = cyc + 1;
        pr = '0; rl = '0; rp = '0;
        if (r) begin
            m_d1 = '1; m_d2 = '1; m_acc = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            rst_edge[n] = 1'b1;
        end else begin
            s    = m_d2;
            m_d2 = m_d1;
            m_d1 = kn;
            for (int i = 0; i < 5; i++) begin
                // s is active-low, m_acc active-high: equal means the sample
                // disagrees with the accepted level.
                if (s[i] == m_acc[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == D + 1) begin
                    m_run[i] = 0;
                    if (m_acc[i]) rl[i] = 1'b1;
                    else begin
                        pr[i]   = 1'b1;
                        m_tp[i] = n;
                    end
                    m_acc[i] = ~m_acc[i];
                end else if (m_acc[i] && MASK[i] && (n - m_tp[i] >= HOLD) &&
                             ((n - m_tp[i] - HOLD) % RPT == 0)) begin
                    rp[i] = 1'b1;
                end
            end
        end
        exp_lvl[n] = m_acc;
        if ((pr | rl | rp) != '0) begin
            e.edge_n = n; e.press = pr; e.rel = rl; e.rpt = rp;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] kn, input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, kn);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        ev_t e;
        if (cyc > 0) begin
            if (rst_edge.exists(cyc)) begin
                compared++;
                if ({key_lvl, key_press, key_rel, key_rpt} !== 20'h0) begin
                    mismatched++;
                    $display("FAIL reset_outputs @%0d: got %h expected 0", cyc,
                             {key_lvl, key_press, key_rel, key_rpt});
                end
            end
            if (exp_lvl.exists(cyc)) begin
                compared++;
                if (key_lvl !== exp_lvl[cyc]) begin
                    mismatched++;
                    $display("FAIL key_lvl @%0d: got %b expected %b", cyc, key_lvl, exp_lvl[cyc]);
                end
            end
            if ((key_press | key_rel | key_rpt) !== 5'b0) begin
                for (int i = 0; i < 5; i++) begin
                    if (key_press[i] === 1'b1) begin obs_press[i]++; last_press_edge[i] = cyc; end
                    if (key_rel[i] === 1'b1)   begin obs_rel[i]++;   last_rel_edge[i] = cyc;   end
                    if (key_rpt[i] === 1'b1)   begin obs_rpt[i]++;   last_rpt_edge[i] = cyc;   end
                end
                if (key_press !== 5'b0) last_press_vec = key_press;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_strobe @%0d: got p=%b r=%b rp=%b expected none",
                             cyc, key_press, key_rel, key_rpt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_n != cyc || key_press !== e.press ||
                        key_rel !== e.rel || key_rpt !== e.rpt) begin
                        mismatched++;
                        $display("FAIL strobe @%0d: got p=%b r=%b rp=%b expected @%0d p=%b r=%b rp=%b",
                                 cyc, key_press, key_rel, key_rpt,
                                 e.edge_n, e.press, e.rel, e.rpt);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                e = exp_q.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing_strobe @%0d: got none expected p=%b r=%b rp=%b",
                         e.edge_n, e.press, e.rel, e.rpt);
            end
        end
    end

    initial begin
        int         e0;
        int         run_left [5];
        logic [4:0] lvl_n;

        for (int i = 0; i < 5; i++) begin
            m_run[i] = 0; m_tp[i] = 0;
            obs_press[i] = 0; obs_rel[i] = 0; obs_rpt[i] = 0;
            last_press_edge[i] = -1; last_rel_edge[i] = -1; last_rpt_edge[i] = -1;
            run_left[i] = 0;
        end

        // reset
        for (int c = 0; c < 3; c++) step(1'b1, 5'b11111);
        drive(5'b11111, 5);

        // clean press of enter
        snap();
        e0 = cyc + 1;
        drive(5'b11110, 10);
        drive(5'b11111, 20);
        check("clean_press_count", obs_press[0] - base_press[0], 1);
        check("clean_press_edge", last_press_edge[0], e0 + D + 2);
        check("clean_rel_edge", last_rel_edge[0], e0 + 10 + D + 2);
        check("clean_rpt_count", obs_rpt[0] - base_rpt[0], 0);

        // bouncy press of left
        snap();
        drive(5'b10111, 2); drive(5'b11111, 1);
        drive(5'b10111, 2); drive(5'b11111, 1);
        e0 = cyc + 1;
        drive(5'b10111, 12);
        drive(5'b11111, 20);
        check("bouncy_press_count", obs_press[3] - base_press[3], 1);
        check("bouncy_press_edge", last_press_edge[3], e0 + D + 2);
        check("bouncy_rel_count", obs_rel[3] - base_rel[3], 1);

        // glitch on right
        snap();
        drive(5'b01111, 3);
        drive(5'b11111, 15);
        check("glitch_press_count", obs_press[4] - base_press[4], 0);
        check("glitch_rel_count", obs_rel[4] - base_rel[4], 0);

        // long hold on up: auto-repeat
        snap();
        e0 = cyc + 1;
        drive(5'b11101, 60);
        drive(5'b11111, 20);
        check("hold_up_press_count", obs_press[1] - base_press[1], 1);
        check("hold_up_rpt_count", obs_rpt[1] - base_rpt[1], 5);
        check("hold_up_last_rpt_edge", last_rpt_edge[1], e0 + D + 2 + HOLD + 4 * RPT);
        check("hold_up_rel_count", obs_rel[1] - base_rel[1], 1);

        // long hold on enter: repeat masked off
        snap();
        drive(5'b11110, 60);
        drive(5'b11111, 20);
        check("hold_enter_rpt_count", obs_rpt[0] - base_rpt[0], 0);
        check("hold_enter_press_count", obs_press[0] - base_press[0], 1);
        check("hold_enter_rel_count", obs_rel[0] - base_rel[0], 1);

        // up and down together
        snap();
        drive(5'b11001, 10);
        drive(5'b11111, 20);
        check("dual_press_vec", int'(last_press_vec), int'(5'b00110));
        check("dual_press_up", obs_press[1] - base_press[1], 1);
        check("dual_press_down", obs_press[2] - base_press[2], 1);

        // reset while down is held
        snap();
        drive(5'b11011, 15);
        for (int c = 0; c < 3; c++) step(1'b1, 5'b11011);
        e0 = cyc + 1;
        drive(5'b11011, 12);
        drive(5'b11111, 20);
        check("rst_hold_press_count", obs_press[2] - base_press[2], 2);
        check("rst_hold_rel_count", obs_rel[2] - base_rel[2], 1);
        check("rst_hold_press_edge", last_press_edge[2], e0 + D + 2);

        // random runs on all keys, occasional reset
        lvl_n = 5'b11111;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 5; k++) begin
                if (run_left[k] == 0) begin
                    lvl_n[k] = ~lvl_n[k];
                    if ($urandom_range(0, 3) == 0) run_left[k] = int'($urandom_range(20, 70));
                    else run_left[k] = int'($urandom_range(1, 7));
                end
                run_left[k]--;
            end
            if ($urandom_range(0, 499) == 0) begin
                step(1'b1, lvl_n);
                step(1'b1, lvl_n);
            end else begin
                step(1'b0, lvl_n);
            end
        end
        drive(5'b11111, 40);

        check("leftover_expected_events", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
